// File: rtl/stream_toggle_rx.sv
// stream_toggle_rx: toggle-handshake receiver feeding a 2-entry valid/ready stream
module stream_toggle_rx #(
  parameter int DataBits   = 8,
  parameter int SyncStages = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_toggle,
  input  logic [DataBits-1:0] req_data,
  output logic                ack_toggle,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DataBits-1:0] out_data,
  output logic [1:0]          level
);
  logic [SyncStages-1:0] sync;
  logic [DataBits-1:0]   skid;
  logic                  req_s, pending, cap, pop;
  logic [1:0]            level_nxt;
  assign req_s     = sync[SyncStages-1];
  assign pending   = req_s ^ ack_toggle;
  assign cap       = pending && level != 2'd2;
  assign out_valid = level != 2'd0;
  assign pop       = out_valid && out_ready;
  assign level_nxt = level + 2'(cap) - 2'(pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync       <= '0;
      ack_toggle <= 1'b0;
      level      <= 2'd0;
      out_data   <= '0;
      skid       <= '0;
    end else begin
      sync  <= {sync[SyncStages-2:0], req_toggle};
      level <= level_nxt;
      if (cap) ack_toggle <= ~ack_toggle;
      if (cap && (level == 2'd0 || (level == 2'd1 && pop))) out_data <= req_data;
      else if (pop && level == 2'd2) out_data <= skid;
      if (cap && level == 2'd1 && !pop) skid <= req_data;
    end
endmodule

// File: tb/tb_stream_toggle_rx.sv
// tb_stream_toggle_rx: directed vector table plus handshake sequences for stream_toggle_rx
module tb_stream_toggle_rx;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req_toggle = 1'b0, out_ready = 1'b0, ack_toggle, out_valid;
  logic [7:0] req_data = 8'h00, out_data;
  logic [1:0] level;
  logic       tog4 = 1'b0, ack4, valid4;
  logic [7:0] data4 = 8'h00, out4;
  logic [1:0] level4;
  int         errors = 0, checks = 0;
  logic       mon_en = 1'b0, last_ack = 1'b0;
  int         words = 0, flips = 0, max_level = 0;
  logic [7:0] exp_word = 8'h01;

  typedef struct packed {
    logic       tog;
    logic [7:0] data;
    logic       rdy;
    logic       v;
    logic       a;
    logic [1:0] l;
    logic [7:0] d;
  } vec_t;
  vec_t vecs [23];

  stream_toggle_rx #(.DataBits(8), .SyncStages(2)) dut (
    .clk(clk), .rst(rst), .req_toggle(req_toggle), .req_data(req_data),
    .ack_toggle(ack_toggle), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level));

  stream_toggle_rx #(.DataBits(8), .SyncStages(4)) dut4 (
    .clk(clk), .rst(rst), .req_toggle(tog4), .req_data(data4),
    .ack_toggle(ack4), .out_valid(valid4), .out_ready(1'b0),
    .out_data(out4), .level(level4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    req_data   = d;
    req_toggle = ~req_toggle;
    while (ack_toggle !== req_toggle && k < 30) begin
      step();
      k++;
    end
    chk("send_ack", 16'(ack_toggle), 16'(req_toggle));
  endtask

  // counts acks and checks popped words against the sender's sequence
  always @(negedge clk) if (mon_en) begin
    if (out_valid && out_ready) begin
      chk("b2b_order", 16'(out_data), 16'(exp_word));
      exp_word = exp_word + 8'd1;
      words++;
    end
    if (ack_toggle !== last_ack) flips++;
    last_ack = ack_toggle;
    if (int'(level) > max_level) max_level = int'(level);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          tog   data   rdy   v     a     l      d
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA5};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 2'd0, 8'hA5};
    vecs[4]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA5};
    vecs[5]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA5};
    vecs[6]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 2'd1, 8'h11};
    vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd1, 8'h11};
    vecs[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'd1, 8'h11};
    vecs[9]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd2, 8'h11};
    vecs[10] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 2'd2, 8'h11};
    vecs[11] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 2'd2, 8'h11};
    vecs[12] = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 2'd2, 8'h11};
    vecs[13] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 2'd1, 8'h22};
    vecs[14] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 2'd1, 8'h33};
    vecs[15] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 2'd0, 8'h33};
    vecs[16] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2'd0, 8'h33};
    vecs[17] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2'd0, 8'h33};
    vecs[18] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
    vecs[19] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
    vecs[20] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
    vecs[21] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 2'd1, 8'h55};
    vecs[22] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 8'h55};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 16'(out_valid), 16'(0));
    chk("reset_ack", 16'(ack_toggle), 16'(0));
    chk("reset_level", 16'(level), 16'(0));
    chk("reset_data", 16'(out_data), 16'(0));
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      req_toggle = vecs[i].tog;
      req_data   = vecs[i].data;
      out_ready  = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].v));
      chk($sformatf("vec%0d_ack", i), 16'(ack_toggle), 16'(vecs[i].a));
      chk($sformatf("vec%0d_level", i), 16'(level), 16'(vecs[i].l));
      chk($sformatf("vec%0d_data", i), 16'(out_data), 16'(vecs[i].d));
    end

    out_ready = 1'b1;
    last_ack  = ack_toggle;
    mon_en    = 1'b1;
    for (int i = 1; i <= 16; i++) send(8'(i));
    repeat (5) step();
    mon_en = 1'b0;
    chk("b2b_words", 16'(words), 16'(16));
    chk("b2b_flips", 16'(flips), 16'(16));
    chk("b2b_max_level_le1", 16'(max_level <= 1), 16'(1));

    out_ready = 1'b0;
    send(8'h66);
    send(8'h77);
    step();
    chk("pre_reset_level", 16'(level), 16'(2));
    @(posedge clk);
    #3;
    rst        = 1'b1;
    req_toggle = 1'b1;
    #1;
    chk("async_rst_valid", 16'(out_valid), 16'(0));
    chk("async_rst_level", 16'(level), 16'(0));
    chk("async_rst_ack", 16'(ack_toggle), 16'(0));
    step();
    chk("in_rst_no_capture", 16'(level), 16'(0));
    rst = 1'b0;
    step();
    step();
    chk("rel_edge2_valid", 16'(out_valid), 16'(0));
    step();
    chk("rel_edge3_valid", 16'(out_valid), 16'(1));
    chk("rel_edge3_ack", 16'(ack_toggle), 16'(1));
    chk("rel_edge3_data", 16'(out_data), 16'(8'h77));
    step();
    step();
    chk("rel_single_capture", 16'(level), 16'(1));

    data4 = 8'h5A;
    tog4  = 1'b1;
    repeat (4) step();
    chk("sync4_edge4_valid", 16'(valid4), 16'(0));
    step();
    chk("sync4_edge5_valid", 16'(valid4), 16'(1));
    chk("sync4_edge5_ack", 16'(ack4), 16'(1));
    chk("sync4_edge5_data", 16'(out4), 16'(8'h5A));
    chk("sync4_edge5_level", 16'(level4), 16'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
